izh_neuron_array: RTL and testbench
===================================

Name: izh_neuron_array

Overview:
Time-multiplexed array of NUM_NEURONS Izhikevich neurons sharing one fixed-point update datapath. It is the parametrised successor to the single-neuron core, with these additions:
- Configurable width and neuron count.
- Per-neuron behaviour presets.
- Tick-driven integration sweeps with one-deep tick queuing and overrun detection.
- A registered spike vector.

Each tick advances every neuron by one dt step. Sits between the stimulus/config front-end and the spike-routing logic.

Parameters:
NUM_NEURONS, 4, neurons in array (2..16); IDX_W = max(1, clog2(NUM_NEURONS))
W, 18, state word width; signed fixed point Q2.(W-2), FRAC = W-2
IW, 8, per-neuron input current width, signed
MON_W, 8, monitor output width (<= W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; ticks ignored while low
tick  in  1  one-cycle pulse requesting one integration sweep
i_cur  in  NUM_NEURONS*IW  per-neuron current, neuron k at [k*IW +: IW], signed
cfg_we  in  1  config write strobe
cfg_idx  in  IDX_W  neuron index for config write
cfg_type  in  3  behaviour preset
mon_sel  in  IDX_W  neuron routed to mon_v
mon_v  out  MON_W  v[mon_sel][W-1 -: MON_W], combinational from state regs
spike_out  out  NUM_NEURONS  spike flags of last completed sweep
sweep_done  out  1  one-cycle pulse when spike_out updates
busy  out  1  high while in RUN or DONE
overrun  out  1  sticky; tick dropped

Behaviour:
Constants are reals scaled by 2^FRAC, truncated toward zero: VTH=0.30, C14=1.40, V0=-0.70, U0=-0.20.

Reset (async, rst_n low):
- All neurons: v=V0, u=U0, type=0.
- spike_out=0, sweep_done=0, busy=0, overrun=0, pending=0, state=IDLE.
- Reset mid-sweep aborts the sweep immediately; no partial results are kept.

Preset table (a_sh, b_sh, c, d):
- 0 RS: 1, 1, -0.65, 0.08
- 1 IB: 1, 1, -0.55, 0.04
- 2 CH: 1, 1, -0.50, 0.02
- 3 FS: 0, 2, -0.65, 0.02
- 4 TC: 1, 2, -0.65, 0.05
- 5 RZ: 0, 2, -0.65, 0.02
- 6 LTS: 1, 2, -0.65, 0.02
- 7: same as 0

FSM states IDLE, RUN, DONE:
- IDLE: tick&en -> RUN next cycle, idx=0, i_cur sampled into i_lat for the whole sweep.
- RUN: update neuron idx each cycle; idx==NUM_NEURONS-1 -> DONE.
- DONE (1 cycle): sweep_done=1 and spike_out=spike_acc, both registered. Then -> RUN (idx=0, pending cleared, i_cur resampled) if pending, else IDLE.
- Latency: tick at cycle t -> neuron k updated at cycle t+1+k; sweep_done high at t+NUM_NEURONS+1, with spike_out valid the same cycle.
- tick&en while busy with pending=0 -> pending=1. With pending=1 -> tick dropped, overrun=1 (sticky until reset).
- en low mid-sweep: the sweep completes; only new ticks are gated.

Per-neuron update (neuron idx, I = sext(i_lat[idx]) << (FRAC-IW+2)):
- If v > VTH (signed compare): v <= c, u <= sat(u+d), spike_acc[idx]=1.
- Else:
  - v <= sat(v + ((vsq + v + (v>>>2) + (C14>>>2) - (u>>>2) + (I>>>2)) >>> 2))
  - u <= sat(u + (((v>>>b_sh) - u) >>> a_sh >>> 4))
  - spike_acc[idx]=0.
- vsq = {p[2W-1], p[W+FRAC-2:FRAC]}, where p = v*v at full 2W width.
- Intermediate sums are computed at W+3 bits. sat() clamps to [-2^(W-1), 2^(W-1)-1]; no wrap-around.

Config:
- cfg_we writes type[cfg_idx] and reinitialises v, u of that neuron to V0, U0. Accepted in any state.
- If it hits the neuron being updated that same cycle, the config write wins. That neuron's spike_acc bit is 0.
- cfg_idx >= NUM_NEURONS is ignored.

Test Plan:
- Reset, NUM_NEURONS=4, W=18: mon_v=0xD3 for all mon_sel; spike_out=0; busy=0; overrun=0.
- Neuron 0 RS, i_cur=0, 200 ticks spaced 10 cycles -> spike_out never set; mon_v stays within 0xD0..0xD8.
- Neuron 1 RS, i_cur[1]=0x7F, ticks -> spike_out[1] pulses within 50 sweeps. Next sweep: mon_v(sel=1)=0xD6 (c=-0.65), u increased by 0x147A. Other bits unaffected.
- Tick at t, second tick at t+1, third at t+2 -> two sweeps complete back to back (sweep_done at t+5 and t+10); overrun=1.
- cfg_we to neuron 2 at the cycle it is updated -> neuron 2 holds V0/U0 with new type; spike_out[2]=0 for that sweep.
- rst_n low mid-RUN -> all outputs reset within the same cycle. After release, first tick yields sweep_done exactly NUM_NEURONS+1 cycles later.
- Saturation: force i_cur=0x7F with FS preset -> v never wraps negative from positive; compare against a golden fixed-point model per update.

Source files
------------

// File: rtl/izh_neuron_array_if.sv
// izh_neuron_array_if
//   Control, stimulus, config, monitor and status signals of izh_neuron_array.
//   master : stimulus/config front-end (drives en, tick, i_cur, cfg_*, mon_sel)
//   slave  : the neuron array (drives mon_v, spike_out, sweep_done, busy, overrun)
//   i_cur packs neuron k at [k*IW +: IW]; mon_v is the top MON_W bits of v[mon_sel].
interface izh_neuron_array_if #(
  parameter int NUM_NEURONS = 4,
  parameter int IW          = 8,
  parameter int MON_W       = 8
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                      en;
  logic                      tick;
  logic [NUM_NEURONS*IW-1:0] i_cur;
  logic                      cfg_we;
  logic [IDX_W-1:0]          cfg_idx;
  logic [2:0]                cfg_type;
  logic [IDX_W-1:0]          mon_sel;
  logic [MON_W-1:0]          mon_v;
  logic [NUM_NEURONS-1:0]    spike_out;
  logic                      sweep_done;
  logic                      busy;
  logic                      overrun;

  modport master (
    output en, tick, i_cur, cfg_we, cfg_idx, cfg_type, mon_sel,
    input  mon_v, spike_out, sweep_done, busy, overrun
  );

  modport slave (
    input  en, tick, i_cur, cfg_we, cfg_idx, cfg_type, mon_sel,
    output mon_v, spike_out, sweep_done, busy, overrun
  );
endinterface

// File: rtl/izh_neuron_array.sv
// izh_neuron_array
//   Time-multiplexed array of NUM_NEURONS Izhikevich neurons sharing a single
//   fixed-point update datapath (state in signed Q2.(W-2)). Each accepted tick
//   runs one sweep that updates neuron 0..NUM_NEURONS-1 on consecutive cycles,
//   then publishes the sweep's spike flags. One extra tick may queue behind a
//   running sweep; any further tick is dropped and flagged in overrun.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : izh_neuron_array_if.slave (en, tick, i_cur, cfg_we, cfg_idx,
//                cfg_type, mon_sel in; mon_v, spike_out, sweep_done, busy,
//                overrun out)
module izh_neuron_array #(
  parameter int NUM_NEURONS = 4,
  parameter int W           = 18,
  parameter int IW          = 8,
  parameter int MON_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  izh_neuron_array_if.slave  bus
);
  localparam int     IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int     FRAC  = W - 2;
  localparam int     EW    = W + 3;  // headroom for the intermediate sums
  localparam longint SCALE = longint'(1) << FRAC;

  // Constants truncated toward zero (SV integer division does that).
  localparam logic signed [EW-1:0] VTH_E = EW'((30 * SCALE) / 100);
  localparam logic signed [EW-1:0] C14_E = EW'((140 * SCALE) / 100);
  localparam logic signed [EW-1:0] C14_Q = C14_E >>> 2;
  localparam logic signed [W-1:0]  V0    = W'((-70 * SCALE) / 100);
  localparam logic signed [W-1:0]  U0    = W'((-20 * SCALE) / 100);
  localparam logic signed [W-1:0]  C_65  = W'((-65 * SCALE) / 100);
  localparam logic signed [W-1:0]  C_55  = W'((-55 * SCALE) / 100);
  localparam logic signed [W-1:0]  C_50  = W'((-50 * SCALE) / 100);
  localparam logic signed [EW-1:0] D_08  = EW'((8 * SCALE) / 100);
  localparam logic signed [EW-1:0] D_05  = EW'((5 * SCALE) / 100);
  localparam logic signed [EW-1:0] D_04  = EW'((4 * SCALE) / 100);
  localparam logic signed [EW-1:0] D_02  = EW'((2 * SCALE) / 100);
  localparam logic signed [EW-1:0] SMAX  = EW'((longint'(1) << (W - 1)) - 1);
  localparam logic signed [EW-1:0] SMIN  = EW'(-(longint'(1) << (W - 1)));
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W:0]       CNT      = (IDX_W + 1)'(NUM_NEURONS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_reg, state_next;
  logic                      pending_reg, pending_next;
  logic                      overrun_reg, overrun_next;
  logic                      start, upd, tick_acc;
  logic [IDX_W-1:0]          idx_reg;
  logic [NUM_NEURONS*IW-1:0] i_lat_reg;
  logic [NUM_NEURONS-1:0]    spike_acc_reg, spike_out_reg, cfg_hit;
  logic                      sweep_done_reg;
  logic signed [W-1:0]       v_reg [NUM_NEURONS];
  logic signed [W-1:0]       u_reg [NUM_NEURONS];
  logic [2:0]                type_reg [NUM_NEURONS];

  function automatic logic signed [W-1:0] sat(input logic signed [EW-1:0] x);
    if (x > SMAX)      return SMAX[W-1:0];
    else if (x < SMIN) return SMIN[W-1:0];
    else               return x[W-1:0];
  endfunction

  // Config writes decode per neuron; out-of-range indices match nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_cfg
      assign cfg_hit[gi] = bus.cfg_we && (bus.cfg_idx == IDX_W'(gi));
    end
  endgenerate

  // ---------------- shared update datapath ----------------
  logic signed [W-1:0]    v_cur, u_cur, c_w, vsq, v_new, u_new;
  logic [2:0]             t_cur;
  logic [IW-1:0]          i_sel;
  logic                   a_sh, fire;
  logic [1:0]             b_sh;
  logic signed [EW-1:0]   d_e, v_e, u_e, vsq_e, i_e, dv_sum, v_sum, vb, du, u_sum, u_spk;
  logic signed [2*W-1:0]  sq;

  assign v_cur = v_reg[idx_reg];
  assign u_cur = u_reg[idx_reg];
  assign t_cur = type_reg[idx_reg];
  assign i_sel = i_lat_reg[idx_reg*IW +: IW];

  always_comb begin
    a_sh = 1'b1; b_sh = 2'd1; c_w = C_65; d_e = D_08;  // RS, also types 0 and 7
    case (t_cur)
      3'd1: begin c_w = C_55; d_e = D_04; end
      3'd2: begin c_w = C_50; d_e = D_02; end
      3'd3: begin a_sh = 1'b0; b_sh = 2'd2; d_e = D_02; end
      3'd4: begin b_sh = 2'd2; d_e = D_05; end
      3'd5: begin a_sh = 1'b0; b_sh = 2'd2; d_e = D_02; end
      3'd6: begin b_sh = 2'd2; d_e = D_02; end
      default: ;
    endcase
  end

  always_comb begin
    v_e    = {{3{v_cur[W-1]}}, v_cur};
    u_e    = {{3{u_cur[W-1]}}, u_cur};
    sq     = $signed({{W{v_cur[W-1]}}, v_cur}) * $signed({{W{v_cur[W-1]}}, v_cur});
    // v*v rescaled to Q2.FRAC; the integer bits above bit 0 are deliberately dropped.
    vsq    = {sq[2*W-1], sq[W+FRAC-2:FRAC]};
    vsq_e  = {{3{vsq[W-1]}}, vsq};
    i_e    = {{3{i_sel[IW-1]}}, i_sel, {(W-IW){1'b0}}};  // sext(I) << (FRAC-IW+2)
    dv_sum = vsq_e + v_e + (v_e >>> 2) + C14_Q - (u_e >>> 2) + (i_e >>> 2);
    v_sum  = v_e + (dv_sum >>> 2);
    vb     = v_e >>> b_sh;
    du     = ((vb - u_e) >>> a_sh) >>> 4;
    u_sum  = u_e + du;
    u_spk  = u_e + d_e;
    fire   = (v_e > VTH_E);
    v_new  = fire ? c_w : sat(v_sum);
    u_new  = fire ? sat(u_spk) : sat(u_sum);
  end

  // ---------------- sweep sequencer ----------------
  always_comb begin
    tick_acc     = bus.tick & bus.en;
    state_next   = state_reg;
    pending_next = pending_reg;
    overrun_next = overrun_reg;
    start        = 1'b0;
    upd          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick_acc) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        upd = 1'b1;
        if (tick_acc) begin
          if (pending_reg) overrun_next = 1'b1;
          else             pending_next = 1'b1;
        end
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        // A tick arriving in DONE itself restarts like a queued one, so it is
        // never stranded in pending while the FSM idles.
        if (pending_reg || tick_acc) begin
          state_next = RUN;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
        pending_next = pending_reg & tick_acc;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pending_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
      idx_reg        <= '0;
      i_lat_reg      <= '0;
      spike_acc_reg  <= '0;
      spike_out_reg  <= '0;
      sweep_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      overrun_reg    <= overrun_next;
      sweep_done_reg <= (state_reg == DONE);
      if (state_reg == DONE) spike_out_reg <= spike_acc_reg;
      if (start) begin
        idx_reg   <= '0;
        i_lat_reg <= bus.i_cur;
      end else if (upd) begin
        idx_reg <= idx_reg + 1'b1;
      end
      if (upd) spike_acc_reg[idx_reg] <= fire & ~cfg_hit[idx_reg];
    end
  end

  // Neuron state: a config write to the neuron under update overrides the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_reg[k]    <= V0;
        u_reg[k]    <= U0;
        type_reg[k] <= 3'd0;
      end
    end else begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (cfg_hit[k]) begin
          v_reg[k]    <= V0;
          u_reg[k]    <= U0;
          type_reg[k] <= bus.cfg_type;
        end else if (upd && (idx_reg == IDX_W'(k))) begin
          v_reg[k] <= v_new;
          u_reg[k] <= u_new;
        end
      end
    end
  end

  logic mon_ok;
  assign mon_ok         = ({1'b0, bus.mon_sel} < CNT);
  assign bus.mon_v      = mon_ok ? v_reg[bus.mon_sel][W-1 -: MON_W] : '0;
  assign bus.spike_out  = spike_out_reg;
  assign bus.sweep_done = sweep_done_reg;
  assign bus.busy       = (state_reg == RUN) || (state_reg == DONE);
  assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_izh_neuron_array.sv
// tb_izh_neuron_array
//   Directed tests for izh_neuron_array (NUM_NEURONS=4, W=18, IW=8, MON_W=8).
//   A small fixed-point reference model of the neurons supplies expected
//   spike vectors and monitor values sweep by sweep.
module tb_izh_neuron_array;
  localparam int N = 4, W = 18, IW = 8, MON_W = 8;
  // Hand-scaled Q2.16 constants (truncated toward zero).
  localparam longint VTH = 19660, V0 = -45875, U0 = -13107, C14Q = 22937;
  localparam longint SMAX = 131071, SMIN = -131072;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  izh_neuron_array_if #(.NUM_NEURONS(N), .IW(IW), .MON_W(MON_W)) bus();
  izh_neuron_array #(.NUM_NEURONS(N), .W(W), .IW(IW), .MON_W(MON_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  longint mv[N];
  longint mu[N];
  int mt[N];

  // ---------------- reference model ----------------
  function automatic longint msat(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  task automatic preset(input int t, output int a, output int b, output longint c, output longint d);
    a = 1; b = 1; c = -42598; d = 5242;
    case (t)
      1: begin c = -36044; d = 2621; end
      2: begin c = -32768; d = 1310; end
      3: begin a = 0; b = 2; d = 1310; end
      4: begin b = 2; d = 3276; end
      5: begin a = 0; b = 2; d = 1310; end
      6: begin b = 2; d = 1310; end
      default: ;
    endcase
  endtask

  task automatic model_init(input int k, input int t);
    mv[k] = V0; mu[k] = U0; mt[k] = t;
  endtask

  // skip >= 0 marks a neuron hit by a config write during its update slot.
  task automatic model_sweep(input logic [N*IW-1:0] icur, input int skip, input int skip_t,
                             output logic [N-1:0] spk);
    int a, b;
    longint c, d, i, vsq, s;
    for (int k = 0; k < N; k++) begin
      spk[k] = 1'b0;
      if (k == skip) begin
        model_init(k, skip_t);
      end else begin
        preset(mt[k], a, b, c, d);
        i = longint'($signed(icur[k*IW +: IW])) * 1024;
        if (mv[k] > VTH) begin
          mv[k] = c;
          mu[k] = msat(mu[k] + d);
          spk[k] = 1'b1;
        end else begin
          vsq = ((mv[k] * mv[k]) >> 16) & 64'h1FFFF;
          s = vsq + mv[k] + (mv[k] >>> 2) + C14Q - (mu[k] >>> 2) + (i >>> 2);
          d = ((((mv[k] >>> b) - mu[k]) >>> a) >>> 4);
          mv[k] = msat(mv[k] + (s >>> 2));
          mu[k] = msat(mu[k] + d);
        end
      end
    end
  endtask

  function automatic logic [MON_W-1:0] mon_exp(input int k);
    logic [W-1:0] vb;
    vb = mv[k][W-1:0];
    return vb[W-1 -: MON_W];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) model_init(k, 0);
  endtask

  task automatic cfg_write(input int idx, input int t);
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'(idx); bus.cfg_type = 3'(t);
    step;
    bus.cfg_we = 1'b0;
    model_init(idx, t);
  endtask

  // Pulse tick and wait (bounded) for sweep_done; lat = cycles from tick edge, -1 on timeout.
  task automatic run_sweep(output int lat);
    bus.tick = 1'b1;
    step;
    bus.tick = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      step;
      if (bus.sweep_done) begin
        lat = c;
        break;
      end
    end
    $display("sweep: latency=%0d spike_out=%b", lat, bus.spike_out);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    step;
    for (int k = 0; k < N; k++) begin
      bus.mon_sel = 2'(k);
      #1;
      total++;
      if (bus.mon_v !== 8'hD3) begin bad++; $display("FAIL reset_mon[%0d]: got %h want d3", k, bus.mon_v); end
    end
    total++; if (bus.spike_out !== 4'b0) begin bad++; $display("FAIL reset_spike: got %b want 0000", bus.spike_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    total++; if (bus.sweep_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.sweep_done); end
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) model_init(k, 0);
    step;
  endtask

  task automatic test_rest;
    int lat;
    logic [N-1:0] spk;
    apply_reset;
    bus.i_cur = '0;
    bus.mon_sel = 2'd0;
    for (int s = 0; s < 30; s++) begin
      run_sweep(lat);
      model_sweep(bus.i_cur, -1, 0, spk);
      total++; if (lat !== 5) begin bad++; $display("FAIL rest_latency s%0d: got %0d want 5", s, lat); end
      total++; if (bus.spike_out !== spk) begin bad++; $display("FAIL rest_spike s%0d: got %b want %b", s, bus.spike_out, spk); end
      total++; if (bus.mon_v !== mon_exp(0)) begin bad++; $display("FAIL rest_mon s%0d: got %h want %h", s, bus.mon_v, mon_exp(0)); end
      repeat (3) step;
    end
  endtask

  task automatic test_spike;
    int lat;
    logic [N-1:0] spk;
    bit seen;
    apply_reset;
    bus.i_cur = 32'h0000_7F00;
    bus.mon_sel = 2'd1;
    seen = 1'b0;
    for (int s = 0; s < 50 && !seen; s++) begin
      run_sweep(lat);
      model_sweep(bus.i_cur, -1, 0, spk);
      total++; if (bus.spike_out !== spk) begin bad++; $display("FAIL spike_vec s%0d: got %b want %b", s, bus.spike_out, spk); end
      total++; if (bus.mon_v !== mon_exp(1)) begin bad++; $display("FAIL spike_mon s%0d: got %h want %h", s, bus.mon_v, mon_exp(1)); end
      seen = bus.spike_out[1];
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL spike_seen: got %b want 1", seen); end
    total++; if (bus.mon_v !== 8'hD6) begin bad++; $display("FAIL spike_reset_v: got %h want d6", bus.mon_v); end
    total++; if ({bus.spike_out[3:2], bus.spike_out[0]} !== 3'b000) begin bad++; $display("FAIL spike_others: got %b want 0x00", bus.spike_out); end
    // The next sweeps run from v=c, u+d; the model follows through them.
    for (int s = 0; s < 3; s++) begin
      run_sweep(lat);
      model_sweep(bus.i_cur, -1, 0, spk);
      total++; if (bus.mon_v !== mon_exp(1)) begin bad++; $display("FAIL spike_after s%0d: got %h want %h", s, bus.mon_v, mon_exp(1)); end
    end
  endtask

  task automatic test_back_to_back;
    int first, second, n;
    logic [N-1:0] spk;
    apply_reset;
    bus.i_cur = '0;
    first = -1; second = -1; n = 0;
    for (int c = 0; c <= 20; c++) begin
      bus.tick = (c < 3);
      step;
      if (bus.sweep_done) begin
        n++;
        if (first < 0) first = c; else if (second < 0) second = c;
      end
    end
    bus.tick = 1'b0;
    $display("back_to_back: done at %0d and %0d, count=%0d", first, second, n);
    total++; if (first !== 5) begin bad++; $display("FAIL b2b_first: got %0d want 5", first); end
    total++; if (second !== 10) begin bad++; $display("FAIL b2b_second: got %0d want 10", second); end
    total++; if (n !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", n); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun: got %b want 1", bus.overrun); end
    model_sweep(bus.i_cur, -1, 0, spk);
    model_sweep(bus.i_cur, -1, 0, spk);
    for (int k = 0; k < N; k++) begin
      bus.mon_sel = 2'(k);
      #1;
      total++; if (bus.mon_v !== mon_exp(k)) begin bad++; $display("FAIL b2b_mon[%0d]: got %h want %h", k, bus.mon_v, mon_exp(k)); end
    end
  endtask

  task automatic test_cfg_collision;
    int lat;
    logic [N-1:0] spk;
    apply_reset;
    bus.i_cur = 32'h7F7F_7F7F;
    // Advance until neuron 2 is above threshold, so it would spike next sweep.
    for (int s = 0; s < 40 && mv[2] <= VTH; s++) begin
      run_sweep(lat);
      model_sweep(bus.i_cur, -1, 0, spk);
    end
    total++; if (mv[2] <= VTH) begin bad++; $display("FAIL cfg_setup: neuron 2 v=%0d want above %0d", mv[2], VTH); end
    bus.tick = 1'b1;
    step;                      // tick edge
    bus.tick = 1'b0;
    step;                      // neuron 0
    step;                      // neuron 1
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'd2; bus.cfg_type = 3'd3;
    step;                      // neuron 2 update collides with the config write
    bus.cfg_we = 1'b0;
    lat = -1;
    for (int c = 4; c <= 30; c++) begin
      step;
      if (bus.sweep_done) begin lat = c; break; end
    end
    $display("cfg_collision sweep: latency=%0d spike_out=%b", lat, bus.spike_out);
    model_sweep(bus.i_cur, 2, 3, spk);
    total++; if (lat !== 5) begin bad++; $display("FAIL cfg_latency: got %0d want 5", lat); end
    total++; if (bus.spike_out !== spk) begin bad++; $display("FAIL cfg_spike: got %b want %b", bus.spike_out, spk); end
    total++; if (bus.spike_out[2] !== 1'b0) begin bad++; $display("FAIL cfg_spike2: got %b want 0", bus.spike_out[2]); end
    bus.mon_sel = 2'd2;
    #1;
    total++; if (bus.mon_v !== 8'hD3) begin bad++; $display("FAIL cfg_v0: got %h want d3", bus.mon_v); end
    // Following sweeps exercise the new FS preset on neuron 2.
    for (int s = 0; s < 4; s++) begin
      run_sweep(lat);
      model_sweep(bus.i_cur, -1, 0, spk);
      total++; if (bus.mon_v !== mon_exp(2)) begin bad++; $display("FAIL cfg_fs_mon s%0d: got %h want %h", s, bus.mon_v, mon_exp(2)); end
      total++; if (bus.spike_out !== spk) begin bad++; $display("FAIL cfg_fs_spike s%0d: got %b want %b", s, bus.spike_out, spk); end
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, extra;
    logic [N-1:0] spk;
    apply_reset;
    bus.i_cur = 32'h7F7F_7F7F;
    for (int c = 0; c < 3; c++) begin
      bus.tick = 1'b1;
      step;
    end
    bus.tick = 1'b0;
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL midrst_pre_overrun: got %b want 1", bus.overrun); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun: got %b want 0", bus.overrun); end
    total++; if (bus.spike_out !== 4'b0) begin bad++; $display("FAIL midrst_spike: got %b want 0000", bus.spike_out); end
    for (int k = 0; k < 2; k++) begin
      bus.mon_sel = 2'(k);
      #1;
      total++; if (bus.mon_v !== 8'hD3) begin bad++; $display("FAIL midrst_mon[%0d]: got %h want d3", k, bus.mon_v); end
    end
    step;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) model_init(k, 0);
    bus.mon_sel = 2'd0;
    run_sweep(lat);
    model_sweep(bus.i_cur, -1, 0, spk);
    total++; if (lat !== 5) begin bad++; $display("FAIL midrst_latency: got %0d want 5", lat); end
    total++; if (bus.mon_v !== mon_exp(0)) begin bad++; $display("FAIL midrst_mon_after: got %h want %h", bus.mon_v, mon_exp(0)); end
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      step;
      if (bus.sweep_done) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL midrst_no_pending: got %0d extra sweeps want 0", extra); end
  endtask

  task automatic test_enable;
    int lat, n;
    logic [N-1:0] spk;
    apply_reset;
    bus.i_cur = '0;
    bus.tick = 1'b1;
    step;
    bus.tick = 1'b0;
    bus.en = 1'b0;             // dropped mid-sweep: the sweep still finishes
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step;
      if (bus.sweep_done) begin lat = c; break; end
    end
    $display("enable sweep: latency=%0d", lat);
    model_sweep(bus.i_cur, -1, 0, spk);
    total++; if (lat !== 5) begin bad++; $display("FAIL en_finish: got %0d want 5", lat); end
    bus.tick = 1'b1;
    step;
    bus.tick = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step;
      if (bus.sweep_done || bus.busy) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL en_gated: got %0d active cycles want 0", n); end
    bus.en = 1'b1;
    bus.mon_sel = 2'd3;
    #1;
    total++; if (bus.mon_v !== mon_exp(3)) begin bad++; $display("FAIL en_mon: got %h want %h", bus.mon_v, mon_exp(3)); end
  endtask

  task automatic test_saturation;
    int lat;
    logic [N-1:0] spk;
    apply_reset;
    cfg_write(3, 3);
    cfg_write(0, 4);
    bus.i_cur = 32'h7F7F_7F7F;
    for (int s = 0; s < 40; s++) begin
      run_sweep(lat);
      model_sweep(bus.i_cur, -1, 0, spk);
      total++; if (bus.spike_out !== spk) begin bad++; $display("FAIL sat_spike s%0d: got %b want %b", s, bus.spike_out, spk); end
      for (int k = 0; k < N; k++) begin
        bus.mon_sel = 2'(k);
        #1;
        total++; if (bus.mon_v !== mon_exp(k)) begin bad++; $display("FAIL sat_mon[%0d] s%0d: got %h want %h", k, s, bus.mon_v, mon_exp(k)); end
      end
    end
  endtask

  initial begin
    bus.en = 1'b1; bus.tick = 1'b0; bus.i_cur = '0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_type = '0; bus.mon_sel = '0;
    test_reset;
    test_rest;
    test_spike;
    test_back_to_back;
    test_cfg_collision;
    test_reset_mid_run;
    test_enable;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
